// File: rtl/car_alarm_pkg.sv
// Shared types and constants for the car alarm controller.
package car_alarm_pkg;

  // FSM state encoding; also driven out on AlarmState.
  typedef enum logic [2:0] {
    StDisarmed = 3'd0,
    StExit     = 3'd1,
    StArmed    = 3'd2,
    StEntry    = 3'd3,
    StAlarm    = 3'd4
  } alarmStateT;

  localparam logic [7:0] COUNT_MAX = 8'hFF;

  // True in states that run the shared down-counter.
  function automatic logic isTimedState(alarmStateT s);
    return (s == StExit) || (s == StEntry) || (s == StAlarm);
  endfunction

endpackage

// File: rtl/alarm_timer.sv
// Loadable down-counter with zero flag; never decrements below zero.
module alarm_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             load,
  input  logic [CNT_W-1:0] loadValue,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Load has priority over decrement; saturate at zero.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/car_alarm_controller.sv
// Car alarm arm/disarm FSM with exit delay, entry delay and timed siren.
// Optional feature: define CAR_ALARM_EVENT_COUNT_EN to add the AlarmCount port.
module car_alarm_controller
  import car_alarm_pkg::*;
#(
  parameter int unsigned NUM_DOORS    = 4,
  parameter int unsigned EXIT_DELAY   = 16,
  parameter int unsigned ENTRY_DELAY  = 16,
  parameter int unsigned SIREN_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 ArmRequest,
  input  logic                 DisarmRequest,
  input  logic [NUM_DOORS-1:0] OpenDoorSign,
  input  logic                 IgnitionSignalOn,
  input  logic                 CarLightsOnSign,
  output logic                 CarAlarmSignal,
  output logic                 LightsWarning,
  output logic                 Armed,
  output logic [2:0]           AlarmState,
  output logic [NUM_DOORS-1:0] TriggerDoors
`ifdef CAR_ALARM_EVENT_COUNT_EN
  ,
  output logic [7:0]           AlarmCount
`endif
);

  localparam int unsigned MAX_ED    = (EXIT_DELAY > ENTRY_DELAY) ? EXIT_DELAY : ENTRY_DELAY;
  localparam int unsigned MAX_DELAY = (MAX_ED > SIREN_CYCLES) ? MAX_ED : SIREN_CYCLES;
  localparam int unsigned CNT_W     = $clog2(MAX_DELAY + 1);

  // Timer holds N-1 on entry so the state lasts exactly N cycles.
  localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_DELAY - 1);
  localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DELAY - 1);
  localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_CYCLES - 1);

  alarmStateT           state;
  alarmStateT           nextState;
  logic [NUM_DOORS-1:0] nextTrigger;
  logic                 timerLoad;
  logic [CNT_W-1:0]     timerLoadValue;
  logic                 timerZero;
  logic                 anyDoorOpen;

  assign anyDoorOpen = |OpenDoorSign;

  alarm_timer #(
    .CNT_W(CNT_W)
  ) uTimer (
    .clk      (clk),
    .reset_L  (reset_L),
    .load     (timerLoad),
    .loadValue(timerLoadValue),
    .dec      (isTimedState(state)),
    .zero     (timerZero)
  );

  // Next-state, trigger accumulation and timer load decode.
  always_comb begin
    nextState      = state;
    nextTrigger    = TriggerDoors;
    timerLoad      = 1'b0;
    timerLoadValue = '0;
    if (DisarmRequest) begin
      nextState   = StDisarmed;
      nextTrigger = '0;
    end else begin
      unique case (state)
        StDisarmed: begin
          if (ArmRequest && !IgnitionSignalOn) begin
            nextState      = StExit;
            timerLoad      = 1'b1;
            timerLoadValue = EXIT_LOAD;
          end
        end
        StExit: begin
          if (timerZero) begin
            if (anyDoorOpen) begin
              nextState      = StEntry;
              nextTrigger    = TriggerDoors | OpenDoorSign;
              timerLoad      = 1'b1;
              timerLoadValue = ENTRY_LOAD;
            end else begin
              nextState = StArmed;
            end
          end
        end
        StArmed: begin
          // Ignition is a stronger intrusion signal than a door.
          if (IgnitionSignalOn) begin
            nextState      = StAlarm;
            timerLoad      = 1'b1;
            timerLoadValue = SIREN_LOAD;
          end else if (anyDoorOpen) begin
            nextState      = StEntry;
            nextTrigger    = TriggerDoors | OpenDoorSign;
            timerLoad      = 1'b1;
            timerLoadValue = ENTRY_LOAD;
          end
        end
        StEntry: begin
          nextTrigger = TriggerDoors | OpenDoorSign;
          if (timerZero) begin
            nextState      = StAlarm;
            timerLoad      = 1'b1;
            timerLoadValue = SIREN_LOAD;
          end
        end
        StAlarm: begin
          if (timerZero) begin
            nextState = StArmed;
          end
        end
        default: begin
          nextState   = StDisarmed;
          nextTrigger = '0;
        end
      endcase
    end
  end

  // State register with Moore outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state          <= StDisarmed;
      TriggerDoors   <= '0;
      CarAlarmSignal <= 1'b0;
      Armed          <= 1'b0;
      AlarmState     <= 3'd0;
    end else begin
      state          <= nextState;
      TriggerDoors   <= nextTrigger;
      CarAlarmSignal <= (nextState == StAlarm);
      Armed          <= (nextState == StArmed) || (nextState == StEntry) ||
                        (nextState == StAlarm);
      AlarmState     <= nextState;
    end
  end

  // Lights-left-on chime, independent of the FSM.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      LightsWarning <= 1'b0;
    end else begin
      LightsWarning <= CarLightsOnSign & anyDoorOpen & ~IgnitionSignalOn;
    end
  end

`ifdef CAR_ALARM_EVENT_COUNT_EN
  // Saturating count of ALARM entries; survives disarm.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      AlarmCount <= 8'd0;
    end else if ((nextState == StAlarm) && (state != StAlarm) && (AlarmCount != COUNT_MAX)) begin
      AlarmCount <= AlarmCount + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_car_alarm_controller.sv
// Directed bench for car_alarm_controller (4 doors, delays 4/3/5).
module tb_car_alarm_controller;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       ArmRequest, DisarmRequest, IgnitionSignalOn, CarLightsOnSign;
  logic [3:0] OpenDoorSign;
  logic       CarAlarmSignal, LightsWarning, Armed;
  logic [2:0] AlarmState;
  logic [3:0] TriggerDoors;
`ifdef CAR_ALARM_EVENT_COUNT_EN
  logic [7:0] AlarmCount;
`endif

  int nCmp = 0;
  int nBad = 0;

  always #5 clk = ~clk;

  car_alarm_controller #(
    .NUM_DOORS   (4),
    .EXIT_DELAY  (4),
    .ENTRY_DELAY (3),
    .SIREN_CYCLES(5)
  ) dut (
    .clk             (clk),
    .reset_L         (reset_L),
    .ArmRequest      (ArmRequest),
    .DisarmRequest   (DisarmRequest),
    .OpenDoorSign    (OpenDoorSign),
    .IgnitionSignalOn(IgnitionSignalOn),
    .CarLightsOnSign (CarLightsOnSign),
    .CarAlarmSignal  (CarAlarmSignal),
    .LightsWarning   (LightsWarning),
    .Armed           (Armed),
    .AlarmState      (AlarmState),
    .TriggerDoors    (TriggerDoors)
`ifdef CAR_ALARM_EVENT_COUNT_EN
    ,
    .AlarmCount      (AlarmCount)
`endif
  );

  typedef struct {
    logic       rst;
    logic       arm;
    logic       dis;
    logic       ign;
    logic       lights;
    logic [3:0] doors;
    logic [2:0] st;
    logic       warn;
    logic [3:0] trig;
  } vecT;

  vecT vecs[$];

  task automatic add(input logic rst, input logic arm, input logic dis, input logic ign,
                     input logic lights, input logic [3:0] doors, input logic [2:0] st,
                     input logic warn, input logic [3:0] trig);
    vecT v;
    v.rst = rst; v.arm = arm; v.dis = dis; v.ign = ign; v.lights = lights;
    v.doors = doors; v.st = st; v.warn = warn; v.trig = trig;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic arm, input logic dis, input logic ign,
                       input logic lights, input logic [3:0] doors);
    reset_L = rst; ArmRequest = arm; DisarmRequest = dis; IgnitionSignalOn = ign;
    CarLightsOnSign = lights; OpenDoorSign = doors;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

    // rst arm dis ign lights doors | state warn trig
    add(0, 1, 1, 1, 1, 4'hF, 0, 0, 4'h0);   // reset dominates all-ones inputs
    add(1, 0, 0, 0, 0, 4'h0, 0, 0, 4'h0);
    add(1, 1, 0, 1, 0, 4'h0, 0, 0, 4'h0);   // arm with ignition on ignored
    add(1, 1, 0, 0, 0, 4'h0, 1, 0, 4'h0);   // EXIT cycle 1
    add(1, 0, 0, 0, 0, 4'h0, 1, 0, 4'h0);
    add(1, 0, 0, 0, 0, 4'h0, 1, 0, 4'h0);
    add(1, 0, 0, 0, 0, 4'h0, 1, 0, 4'h0);   // EXIT cycle 4
    add(1, 1, 0, 0, 0, 4'h0, 2, 0, 4'h0);   // ARMED; arm outside DISARMED ignored
    add(1, 0, 0, 0, 0, 4'h4, 3, 0, 4'h4);   // intrusion door 2
    add(1, 0, 0, 0, 0, 4'h0, 3, 0, 4'h4);
    add(1, 0, 0, 0, 0, 4'h0, 3, 0, 4'h4);
    for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 0, 4'h0, 4, 0, 4'h4);  // siren 5 cycles
    add(1, 0, 0, 0, 0, 4'h0, 2, 0, 4'h4);   // re-armed, trigger sticky
    add(1, 0, 1, 0, 0, 4'h0, 0, 0, 4'h0);   // disarm clears trigger
    add(1, 1, 0, 0, 0, 4'h0, 1, 0, 4'h0);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 4'h0, 1, 0, 4'h0);
    add(1, 0, 0, 0, 0, 4'h0, 2, 0, 4'h0);
    add(1, 0, 0, 0, 0, 4'h2, 3, 0, 4'h2);
    add(1, 0, 0, 0, 0, 4'h1, 3, 0, 4'h3);   // extra door OR'd in
    add(1, 1, 1, 0, 0, 4'h1, 0, 0, 4'h0);   // disarm beats arm
    add(1, 0, 0, 0, 0, 4'h0, 0, 0, 4'h0);
    add(1, 1, 0, 0, 0, 4'h0, 1, 0, 4'h0);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 4'h0, 1, 0, 4'h0);
    add(1, 0, 0, 0, 0, 4'h0, 2, 0, 4'h0);
    add(1, 0, 0, 1, 0, 4'h1, 4, 0, 4'h0);   // ignition wins, straight to ALARM
    for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 0, 4'h0, 4, 0, 4'h0);
    add(1, 0, 0, 0, 0, 4'h0, 2, 0, 4'h0);
    add(1, 0, 1, 0, 0, 4'h0, 0, 0, 4'h0);
    add(1, 0, 0, 0, 1, 4'h8, 0, 1, 4'h0);   // lights warning
    add(1, 0, 0, 1, 1, 4'h8, 0, 0, 4'h0);
    add(1, 0, 0, 0, 1, 4'h0, 0, 0, 4'h0);
    add(1, 1, 0, 0, 0, 4'h8, 1, 0, 4'h0);   // arm with door open
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 4'h8, 1, 0, 4'h0);
    add(1, 0, 0, 0, 0, 4'h8, 3, 0, 4'h8);   // exit expires with door open
    add(1, 0, 0, 0, 0, 4'h0, 3, 0, 4'h8);
    add(1, 0, 0, 0, 0, 4'h0, 3, 0, 4'h8);
    add(1, 0, 0, 0, 0, 4'h0, 4, 0, 4'h8);
    add(1, 0, 0, 0, 0, 4'h4, 4, 0, 4'h8);   // door in ALARM not accumulated
    add(0, 0, 0, 0, 1, 4'h4, 0, 0, 4'h0);   // reset mid-ALARM

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].arm, vecs[i].dis, vecs[i].ign, vecs[i].lights, vecs[i].doors);
      check("AlarmState", i, {5'd0, AlarmState}, {5'd0, vecs[i].st});
      check("CarAlarmSignal", i, {7'd0, CarAlarmSignal}, {7'd0, vecs[i].st == 3'd4});
      check("Armed", i, {7'd0, Armed}, {7'd0, vecs[i].st >= 3'd2});
      check("LightsWarning", i, {7'd0, LightsWarning}, {7'd0, vecs[i].warn});
      check("TriggerDoors", i, {4'd0, TriggerDoors}, {4'd0, vecs[i].trig});
    end

    // Measured delays: arm, wait for ARMED, intrude, time ENTRY and ALARM.
    drive(1, 0, 0, 0, 0, 4'h0);
    drive(1, 1, 0, 0, 0, 4'h0);
    n = 0;
    while (AlarmState != 3'd2 && n < 20) begin
      drive(1, 0, 0, 0, 0, 4'h0);
      n++;
    end
    check("exit_cycles", 0, 8'(n), 8'd4);
    drive(1, 0, 0, 0, 0, 4'h1);
    n = 0;
    while (AlarmState == 3'd3 && n < 20) begin
      drive(1, 0, 0, 0, 0, 4'h0);
      n++;
    end
    check("entry_cycles", 0, 8'(n), 8'd3);
    n = 0;
    while (CarAlarmSignal && n < 20) begin
      drive(1, 0, 0, 0, 0, 4'h0);
      n++;
    end
    check("siren_cycles", 0, 8'(n), 8'd5);
    check("rearm_state", 0, {5'd0, AlarmState}, 8'd2);
    check("rearm_trig", 0, {4'd0, TriggerDoors}, 8'h1);

`ifdef CAR_ALARM_EVENT_COUNT_EN
    // Ignition held in ARMED re-fires ALARM every 6 cycles; counter saturates.
    drive(0, 0, 0, 0, 0, 4'h0);
    check("count_reset", 0, AlarmCount, 8'd0);
    drive(1, 1, 0, 0, 0, 4'h0);
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 0, 4'h0);
    drive(1, 0, 0, 1, 0, 4'h0);
    check("count_first", 0, AlarmCount, 8'd1);
    for (int i = 0; i < 1700; i++) drive(1, 0, 0, 1, 0, 4'h0);
    drive(1, 0, 1, 0, 0, 4'h0);
    check("count_sat", 0, AlarmCount, 8'd255);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
